// File: rtl/real_adder_pipe.sv
// Pipelined IEEE-754 double adder: one combinational BBFAdd followed by STAGES
// valid/ready register stages. Define REAL_ADDER_PIPE_SUB_EN to add the io_sub port.

module BBFAdd (
   input  logic [63:0] in1,
   input  logic [63:0] in2,
   output logic [63:0] out
);
   localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

   function automatic logic [5:0] lzc56(input logic [55:0] v);
      logic [5:0] cnt;
      cnt = 6'd56;
      for (int i = 0; i < 56; i++) begin
         if (v[i]) begin
            cnt = 6'(55 - i);
         end
      end
      return cnt;
   endfunction

   logic        swap_s;
   logic [63:0] x_s;
   logic [63:0] y_s;
   logic        x_nan_s;
   logic        y_nan_s;
   logic        x_inf_s;
   logic        y_inf_s;
   logic        eff_sub_s;
   logic [10:0] ex_s;
   logic [10:0] ey_s;
   logic [10:0] d_s;
   logic [10:0] lim_s;
   logic [52:0] mx_s;
   logic [52:0] my_s;
   logic [5:0]  dcap_s;
   logic [5:0]  lz_s;
   logic [5:0]  shamt_s;
   logic [56:0] mx_ext_s;
   logic [56:0] my_ext_s;
   logic [56:0] my_sh_s;
   logic [56:0] my_al_s;
   logic [56:0] sum_s;
   logic        sticky_s;
   logic [55:0] norm_s;
   logic [11:0] en_s;
   logic [10:0] exp_field_s;
   logic        rnd_s;
   logic [62:0] rounded_s;

   // x is the larger magnitude so the mantissa subtraction never goes negative
   always_comb begin
      swap_s    = (in2[62:0] > in1[62:0]);
      x_s       = swap_s ? in2 : in1;
      y_s       = swap_s ? in1 : in2;
      x_nan_s   = (x_s[62:52] == 11'h7FF) && (x_s[51:0] != 52'd0);
      y_nan_s   = (y_s[62:52] == 11'h7FF) && (y_s[51:0] != 52'd0);
      x_inf_s   = (x_s[62:52] == 11'h7FF) && (x_s[51:0] == 52'd0);
      y_inf_s   = (y_s[62:52] == 11'h7FF) && (y_s[51:0] == 52'd0);
      eff_sub_s = x_s[63] ^ y_s[63];
      ex_s      = (x_s[62:52] == 11'd0) ? 11'd1 : x_s[62:52];
      ey_s      = (y_s[62:52] == 11'd0) ? 11'd1 : y_s[62:52];
      mx_s      = {(x_s[62:52] != 11'd0), x_s[51:0]};
      my_s      = {(y_s[62:52] != 11'd0), y_s[51:0]};
   end

   // align y with three guard bits, folding shifted-out bits into sticky
   always_comb begin
      d_s      = ex_s - ey_s;
      dcap_s   = (d_s > 11'd63) ? 6'd63 : d_s[5:0];
      mx_ext_s = {1'b0, mx_s, 3'b000};
      my_ext_s = {1'b0, my_s, 3'b000};
      my_sh_s  = my_ext_s >> dcap_s;
      sticky_s = ((my_sh_s << dcap_s) != my_ext_s);
      my_al_s  = {my_sh_s[56:1], my_sh_s[0] | sticky_s};
      if (eff_sub_s) begin
         sum_s = mx_ext_s - my_al_s;
      end else begin
         sum_s = mx_ext_s + my_al_s;
      end
   end

   // normalise (left shift limited so the exponent never drops below 1), then round-to-nearest-even
   always_comb begin
      lz_s  = lzc56(sum_s[55:0]);
      lim_s = ex_s - 11'd1;
      if (sum_s[56]) begin
         shamt_s = 6'd0;
         norm_s  = {sum_s[56:2], sum_s[1] | sum_s[0]};
         en_s    = {1'b0, ex_s} + 12'd1;
      end else begin
         shamt_s = ({5'd0, lz_s} > lim_s) ? lim_s[5:0] : lz_s;
         norm_s  = sum_s[55:0] << shamt_s;
         en_s    = {1'b0, ex_s} - {6'd0, shamt_s};
      end
      exp_field_s = norm_s[55] ? en_s[10:0] : 11'd0;
      rnd_s       = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
      rounded_s   = {exp_field_s, norm_s[54:3]} + {62'd0, rnd_s};
   end

   // special operands take priority; an exact zero is +0 unless both inputs are negative
   always_comb begin
      if (x_nan_s || y_nan_s) begin
         out = QNAN;
      end else if (x_inf_s && y_inf_s && eff_sub_s) begin
         out = QNAN;
      end else if (x_inf_s) begin
         out = x_s;
      end else if (sum_s == 57'd0) begin
         out = {x_s[63] & y_s[63], 63'd0};
      end else if ((en_s >= 12'd2047) && norm_s[55]) begin
         out = {x_s[63], 11'h7FF, 52'd0};
      end else begin
         out = {x_s[63], rounded_s};
      end
   end
endmodule

module real_adder_pipe #(
   parameter int STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        io_in_valid,
   output logic        io_in_ready,
   input  logic [63:0] io_a1_node,
   input  logic [63:0] io_a2_node,
`ifdef REAL_ADDER_PIPE_SUB_EN
   input  logic        io_sub,
`endif
   output logic        io_out_valid,
   input  logic        io_out_ready,
   output logic [63:0] io_c_node,
   output logic [3:0]  io_inflight
);
   logic [63:0]       a2_eff_s;
   logic [63:0]       sum_s;
   logic              advance_s;
   logic              in_xfer_s;
   logic              out_xfer_s;
   logic [STAGES-1:0] valid_r;
   logic [63:0]       data_r [STAGES];
   logic [3:0]        inflight_r;

`ifdef REAL_ADDER_PIPE_SUB_EN
   assign a2_eff_s = {io_a2_node[63] ^ io_sub, io_a2_node[62:0]};
`else
   assign a2_eff_s = io_a2_node;
`endif

   BBFAdd u_add (
      .in1 (io_a1_node),
      .in2 (a2_eff_s),
      .out (sum_s)
   );

   assign advance_s    = !valid_r[STAGES-1] | io_out_ready;
   assign in_xfer_s    = io_in_valid & advance_s;
   assign out_xfer_s   = valid_r[STAGES-1] & io_out_ready;
   assign io_in_ready  = advance_s;
   assign io_out_valid = valid_r[STAGES-1];
   assign io_c_node    = data_r[STAGES-1];
   assign io_inflight  = inflight_r;

   // valid chain is cleared asynchronously so no pre-reset result is ever presented
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_r <= {STAGES{1'b0}};
      end else if (advance_s) begin
         valid_r[0] <= io_in_valid;
         for (int i = 1; i < STAGES; i++) begin
            valid_r[i] <= valid_r[i-1];
         end
      end else begin
         valid_r <= valid_r;
      end
   end

   // data stages carry no reset; their content is only meaningful alongside a set valid bit
   always_ff @(posedge clk) begin
      if (advance_s) begin
         data_r[0] <= sum_s;
         for (int i = 1; i < STAGES; i++) begin
            data_r[i] <= data_r[i-1];
         end
      end else begin
         data_r <= data_r;
      end
   end

   // occupancy tracks input transfers minus output transfers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inflight_r <= 4'd0;
      end else begin
         case ({in_xfer_s, out_xfer_s})
            2'b10:   inflight_r <= inflight_r + 4'd1;
            2'b01:   inflight_r <= inflight_r - 4'd1;
            default: inflight_r <= inflight_r;
         endcase
      end
   end
endmodule

// File: tb/tb_real_adder_pipe.sv
// Directed bench for real_adder_pipe: a STAGES=2 and a STAGES=3 instance share clock and reset.
module tb_real_adder_pipe;
   logic        clk = 1'b0;
   logic        reset;
   int          checks = 0;
   int          failures = 0;

   logic        d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready, d2_sub;
   logic [63:0] d2_a1, d2_a2, d2_c;
   logic [3:0]  d2_inflight;
   logic        d3_in_valid, d3_in_ready, d3_out_valid, d3_out_ready, d3_sub;
   logic [63:0] d3_a1, d3_a2, d3_c;
   logic [3:0]  d3_inflight;

   logic [63:0] va [7];
   logic [63:0] vb [7];
   logic [63:0] ve [7];
   logic [63:0] qa [5];
   logic [63:0] qb [5];
   logic [63:0] sb [$];
   int          in_idx, out_idx, model, maxv, lat;
   logic        acc, ox;

   always #5 clk = ~clk;

   real_adder_pipe #(.STAGES(2)) dut2 (
      .clk(clk), .reset(reset), .io_in_valid(d2_in_valid), .io_in_ready(d2_in_ready),
      .io_a1_node(d2_a1), .io_a2_node(d2_a2),
`ifdef REAL_ADDER_PIPE_SUB_EN
      .io_sub(d2_sub),
`endif
      .io_out_valid(d2_out_valid), .io_out_ready(d2_out_ready),
      .io_c_node(d2_c), .io_inflight(d2_inflight)
   );

   real_adder_pipe #(.STAGES(3)) dut3 (
      .clk(clk), .reset(reset), .io_in_valid(d3_in_valid), .io_in_ready(d3_in_ready),
      .io_a1_node(d3_a1), .io_a2_node(d3_a2),
`ifdef REAL_ADDER_PIPE_SUB_EN
      .io_sub(d3_sub),
`endif
      .io_out_valid(d3_out_valid), .io_out_ready(d3_out_ready),
      .io_c_node(d3_c), .io_inflight(d3_inflight)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] fadd(input logic [63:0] a, input logic [63:0] b);
      return $realtobits($bitstoreal(a) + $bitstoreal(b));
   endfunction

   initial begin
      reset = 1'b0;
      d2_in_valid = 1'b0; d2_out_ready = 1'b0; d2_sub = 1'b0; d2_a1 = 64'd0; d2_a2 = 64'd0;
      d3_in_valid = 1'b0; d3_out_ready = 1'b0; d3_sub = 1'b0; d3_a1 = 64'd0; d3_a2 = 64'd0;
      tick();
      tick();
      chk("rst_out_valid2", 64'(d2_out_valid), 64'd0);
      chk("rst_inflight2", 64'(d2_inflight), 64'd0);
      chk("rst_inflight3", 64'(d3_inflight), 64'd0);
      chk("rst_in_ready2", 64'(d2_in_ready), 64'd1);
      reset = 1'b1;
      tick();
      chk("post_rst_in_ready3", 64'(d3_in_ready), 64'd1);

      // 1.0 + 2.0 with two-cycle latency
      d2_out_ready = 1'b1;
      d2_in_valid = 1'b1; d2_a1 = 64'h3FF0_0000_0000_0000; d2_a2 = 64'h4000_0000_0000_0000;
      tick();
      d2_in_valid = 1'b0;
      chk("lat_c1_valid", 64'(d2_out_valid), 64'd0);
      chk("lat_c1_inflight", 64'(d2_inflight), 64'd1);
      tick();
      chk("lat_c2_valid", 64'(d2_out_valid), 64'd1);
      chk("lat_c2_data", d2_c, 64'h4008_0000_0000_0000);
      tick();
      chk("lat_drain_valid", 64'(d2_out_valid), 64'd0);

      // hand-computed vectors streamed back to back
      va[0] = 64'h3FF8_0000_0000_0000; vb[0] = 64'h4002_0000_0000_0000; ve[0] = 64'h400E_0000_0000_0000;
      va[1] = 64'h3FF0_0000_0000_0000; vb[1] = 64'h3FF0_0000_0000_0000; ve[1] = 64'h4000_0000_0000_0000;
      va[2] = 64'h4000_0000_0000_0000; vb[2] = 64'hBFE0_0000_0000_0000; ve[2] = 64'h3FF8_0000_0000_0000;
      va[3] = 64'h4024_0000_0000_0000; vb[3] = 64'h3FD0_0000_0000_0000; ve[3] = 64'h4024_8000_0000_0000;
      va[4] = 64'h3FF0_0000_0000_0000; vb[4] = 64'hBFF0_0000_0000_0000; ve[4] = 64'h0000_0000_0000_0000;
      va[5] = 64'hBFF0_0000_0000_0000; vb[5] = 64'hC000_0000_0000_0000; ve[5] = 64'hC008_0000_0000_0000;
      va[6] = 64'h7FF0_0000_0000_0000; vb[6] = 64'h3FF0_0000_0000_0000; ve[6] = 64'h7FF0_0000_0000_0000;
      for (int i = 0; i < 8; i++) begin
         if (i < 7) begin
            d2_in_valid = 1'b1; d2_a1 = va[i]; d2_a2 = vb[i];
         end else begin
            d2_in_valid = 1'b0;
         end
         tick();
         if (i >= 1) begin
            chk($sformatf("vec%0d_valid", i - 1), 64'(d2_out_valid), 64'd1);
            chk($sformatf("vec%0d_data", i - 1), d2_c, ve[i-1]);
         end
      end
      tick();
      chk("vec_drain_valid", 64'(d2_out_valid), 64'd0);

`ifdef REAL_ADDER_PIPE_SUB_EN
      d2_in_valid = 1'b1; d2_sub = 1'b1;
      d2_a1 = 64'h4008_0000_0000_0000; d2_a2 = 64'h3FF0_0000_0000_0000;
      tick();
      d2_in_valid = 1'b0; d2_sub = 1'b0;
      tick();
      chk("sub_valid", 64'(d2_out_valid), 64'd1);
      chk("sub_data", d2_c, 64'h4000_0000_0000_0000);
      tick();
`endif

      // bubble between two inputs must stay invisible
      d2_in_valid = 1'b1; d2_a1 = 64'h3FF0_0000_0000_0000; d2_a2 = 64'h4000_0000_0000_0000;
      tick();
      chk("bub_t0_valid", 64'(d2_out_valid), 64'd0);
      d2_in_valid = 1'b0;
      tick();
      chk("bub_t1_valid", 64'(d2_out_valid), 64'd1);
      chk("bub_t1_data", d2_c, 64'h4008_0000_0000_0000);
      d2_in_valid = 1'b1; d2_a1 = 64'h3FF8_0000_0000_0000; d2_a2 = 64'h4002_0000_0000_0000;
      tick();
      chk("bub_t2_valid", 64'(d2_out_valid), 64'd0);
      d2_in_valid = 1'b0;
      tick();
      chk("bub_t3_valid", 64'(d2_out_valid), 64'd1);
      chk("bub_t3_data", d2_c, 64'h400E_0000_0000_0000);
      tick();
      chk("bub_t4_valid", 64'(d2_out_valid), 64'd0);

      // STAGES=3 stall: five offered with the consumer blocked
      for (int i = 0; i < 5; i++) begin
         qa[i] = $realtobits(real'(i) + 0.5);
         qb[i] = $realtobits(2.0 * real'(i) + 0.25);
      end
      in_idx = 0; out_idx = 0;
      d3_out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         d3_in_valid = (in_idx < 5);
         d3_a1 = (in_idx < 5) ? qa[in_idx] : 64'd0;
         d3_a2 = (in_idx < 5) ? qb[in_idx] : 64'd0;
         #1;
         acc = d3_in_valid & d3_in_ready;
         tick();
         if (acc) in_idx++;
      end
      #1;
      chk("stall_accepted", 64'(in_idx), 64'd3);
      chk("stall_in_ready", 64'(d3_in_ready), 64'd0);
      chk("stall_inflight", 64'(d3_inflight), 64'd3);
      chk("stall_out_valid", 64'(d3_out_valid), 64'd1);
      chk("stall_data", d3_c, fadd(qa[0], qb[0]));
      tick();
      tick();
      chk("stall_data_stable", d3_c, fadd(qa[0], qb[0]));
      d3_out_ready = 1'b1;
      for (int c = 0; c < 40 && out_idx < 5; c++) begin
         d3_in_valid = (in_idx < 5);
         d3_a1 = (in_idx < 5) ? qa[in_idx] : 64'd0;
         d3_a2 = (in_idx < 5) ? qb[in_idx] : 64'd0;
         #1;
         acc = d3_in_valid & d3_in_ready;
         ox = d3_out_valid & d3_out_ready;
         if (ox) begin
            chk($sformatf("drain%0d_data", out_idx), d3_c, fadd(qa[out_idx], qb[out_idx]));
            out_idx++;
         end
         tick();
         if (acc) in_idx++;
      end
      d3_in_valid = 1'b0;
      chk("drain_out_count", 64'(out_idx), 64'd5);
      chk("drain_in_count", 64'(in_idx), 64'd5);

      // continuous stream with the consumer toggling every cycle
      tick();
      in_idx = 0; out_idx = 0; model = 0; maxv = 0;
      for (int c = 0; c < 200 && out_idx < 20; c++) begin
         d3_out_ready = c[0];
         d3_in_valid = (in_idx < 20);
         d3_a1 = $realtobits(1.25 * real'(in_idx));
         d3_a2 = $realtobits(3.0 - real'(in_idx));
         #1;
         acc = d3_in_valid & d3_in_ready;
         ox = d3_out_valid & d3_out_ready;
         if (ox) begin
            chk("tog_not_spurious", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) chk($sformatf("tog%0d_data", out_idx), d3_c, sb.pop_front());
            out_idx++;
         end
         if (acc) sb.push_back(fadd(d3_a1, d3_a2));
         tick();
         if (acc) in_idx++;
         model = model + int'(acc) - int'(ox);
         chk("tog_inflight", 64'(d3_inflight), 64'(model));
         if (int'(d3_inflight) > maxv) maxv = int'(d3_inflight);
      end
      d3_in_valid = 1'b0;
      chk("tog_out_count", 64'(out_idx), 64'd20);
      chk("tog_max_inflight", 64'(maxv <= 3), 64'd1);

      // reset with two results in flight
      d3_out_ready = 1'b0;
      d3_in_valid = 1'b1; d3_a1 = 64'h4024_0000_0000_0000; d3_a2 = 64'h4024_0000_0000_0000;
      tick();
      tick();
      d3_in_valid = 1'b0;
      chk("mid_pre_inflight", 64'(d3_inflight), 64'd2);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(d3_out_valid), 64'd0);
      chk("mid_rst_inflight", 64'(d3_inflight), 64'd0);
      chk("mid_rst_in_ready", 64'(d3_in_ready), 64'd1);
      tick();
      reset = 1'b1;
      d3_out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("post_rst_no_stale", 64'(d3_out_valid), 64'd0);
      end
      d3_in_valid = 1'b1; d3_a1 = $realtobits(7.5); d3_a2 = $realtobits(0.25);
      tick();
      d3_in_valid = 1'b0;
      lat = 1;
      while (!d3_out_valid && lat < 10) begin
         tick();
         lat++;
      end
      chk("post_rst_latency", 64'(lat), 64'd3);
      chk("post_rst_data", d3_c, 64'h401F_0000_0000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/real_adder_pipe.md
REAL_ADDER_PIPE -- requirements
Module: real_adder_pipe

Interface
REQ-001 SHALL have parameter STAGES, default 2, meaning the number of register stages after the BBFAdd instance; legal range 1..8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port io_in_valid, input, 1 bit: operand pair is valid.
REQ-005 SHALL have port io_in_ready, output, 1 bit: the block accepts the operand pair this cycle.
REQ-006 SHALL have port io_a1_node, input, 64 bits: IEEE-754 double operand 1.
REQ-007 SHALL have port io_a2_node, input, 64 bits: IEEE-754 double operand 2.
REQ-008 SHALL have port io_sub, input, 1 bit: subtract select, sampled with the operands (present only with REAL_ADDER_PIPE_SUB_EN).
REQ-009 SHALL have port io_out_valid, output, 1 bit: io_c_node holds a result.
REQ-010 SHALL have port io_out_ready, input, 1 bit: the consumer takes the result.
REQ-011 SHALL have port io_c_node, output, 64 bits: the sum or difference.
REQ-012 SHALL have port io_inflight, output, 4 bits: count of results held in the pipeline, including the output stage.

Function
REQ-013 SHALL compute io_a1_node + io_a2_node combinationally through one BBFAdd instance (in1=a1, in2=a2'), followed by STAGES data registers.
REQ-014 SHALL set a2' = io_a2_node with bit 63 inverted when the subtract feature is active and io_sub=1; otherwise a2' = io_a2_node.
REQ-015 SHALL advance the pipeline when advance = !io_out_valid | io_out_ready; on advance every stage loads its predecessor, and stage 1 loads the adder output and valid = io_in_valid.
REQ-016 SHALL drive io_in_ready = advance; a transfer occurs on io_in_valid & io_in_ready.
REQ-017 SHALL hold all data and valid bits unchanged when advance=0 (stall); io_c_node stays stable while io_out_valid=1 and io_out_ready=0.
REQ-018 SHALL give a latency of exactly STAGES cycles from input transfer to io_out_valid when there is no stall, and full throughput of one result per cycle.
REQ-019 SHALL let the data registers of invalid stages take any value; io_c_node is meaningful only while io_out_valid=1.
REQ-020 SHALL maintain io_inflight = number of set valid bits: +1 on an input transfer, -1 on an output transfer (io_out_valid & io_out_ready), and unchanged on both or neither; maximum is STAGES.
REQ-021 SHALL handle a simultaneous input and output transfer with a full pipeline without loss or duplication.
REQ-022 SHALL keep a pipeline bubble (io_in_valid=0 on advance) as an invalid slot that is never presented.

Reset
REQ-023 SHALL, while reset=0, clear all valid bits and io_inflight asynchronously: io_out_valid=0, io_inflight=0.
REQ-024 SHALL drive io_in_ready=1 during and immediately after reset; data registers are not reset.
REQ-025 SHALL discard all in-flight results when reset asserts mid-operation; the first post-reset output comes only from a post-reset input.

Configuration
REQ-026 SHALL, with macro REAL_ADDER_PIPE_SUB_EN defined, provide port io_sub and the sign-inversion path of REQ-014.
REQ-027 SHALL, without REAL_ADDER_PIPE_SUB_EN, omit io_sub and always add.

Verification
REQ-028 SHALL cover STAGES=2 with a1=0x3FF0000000000000 (1.0) and a2=0x4000000000000000 (2.0) valid at cycle 0 and io_out_ready=1 -> io_out_valid=1 and io_c_node=0x4008000000000000 (3.0) at cycle 2.
REQ-029 SHALL cover, with SUB_EN, a1=3.0, a2=1.0, io_sub=1 -> io_c_node=0x4000000000000000 (2.0).
REQ-030 SHALL cover STAGES=3 with 5 back-to-back inputs and io_out_ready=0 -> io_in_ready drops after 3 accepted, io_inflight=3, io_c_node stable; release ready -> all 5 results emerge in order, none lost.
REQ-031 SHALL cover a continuous stream with io_out_ready toggling every cycle -> outputs match the inputs one-for-one, and io_inflight never exceeds STAGES.
REQ-032 SHALL cover reset asserted with io_inflight=2 -> io_out_valid=0 and io_inflight=0 immediately, and no stale result after release.
REQ-033 SHALL cover inputs with an idle gap (bubble) -> no spurious io_out_valid pulse.
